// File: rtl/vigna_bus_pkg.sv
// Shared encodings for the vigna valid/ready memory bus and its arbiters.
package vigna_bus_pkg;

    localparam logic IDLE = 1'b0;
    localparam logic BUSY = 1'b1;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    // A strobe of zero marks a read; the memory honours byte, half and word writes.
    localparam logic [3:0] WSTRB_RD = 4'b0000;
    localparam logic [3:0] WSTRB_B  = 4'b0001;
    localparam logic [3:0] WSTRB_H  = 4'b0011;
    localparam logic [3:0] WSTRB_W  = 4'b1111;

endpackage

// File: rtl/arb_rr2.sv
// Two-way pick between instruction and data requesters, round-robin or data-first.
module arb_rr2
    import vigna_bus_pkg::*;
#(
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic req_i,
    input  logic req_d,
    input  logic last,
    output logic gnt
);

    always_comb begin
        gnt = GNT_I;
        if (req_i && req_d) begin
            // On a tie the port that did not win last time goes next.
            gnt = (FIXED_PRIO != 0) ? GNT_D : ~last;
        end else if (req_d) begin
            gnt = GNT_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and data load/store, one access at a time.
module mem_arbiter
    import vigna_bus_pkg::*;
#(
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        i_valid,
    output logic        i_ready,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_wstrb,

    input  logic        d_valid,
    output logic        d_ready,
    input  logic [31:0] d_addr,
    output logic [31:0] d_rdata,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,

    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_addr,
    input  logic [31:0] m_rdata,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb
);

    logic        state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_q, last_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic [3:0]  m_wstrb_q, m_wstrb_d;
    logic        winner;

    arb_rr2 #(
        .FIXED_PRIO(FIXED_PRIO)
    ) u_arb (
        .req_i(i_valid),
        .req_d(d_valid),
        .last (last_q),
        .gnt  (winner)
    );

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_wstrb_d = m_wstrb_q;
        case (state_q)
            IDLE: begin
                if (i_valid || d_valid) begin
                    state_d = BUSY;
                    grant_d = winner;
                    last_d  = winner;
                    if (winner == GNT_D) begin
                        m_addr_d  = d_addr;
                        m_wdata_d = d_wdata;
                        m_wstrb_d = d_wstrb;
                    end else begin
                        m_addr_d  = i_addr;
                        m_wdata_d = i_wdata;
                        m_wstrb_d = i_wstrb;
                    end
                end
            end
            default: begin
                // Leaving BUSY on the ready cycle keeps valid low while memory re-samples it.
                if (m_ready) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            grant_q   <= GNT_I;
            last_q    <= GNT_D;
            m_addr_q  <= 32'h0;
            m_wdata_q <= 32'h0;
            m_wstrb_q <= WSTRB_RD;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_wstrb_q <= m_wstrb_d;
        end
    end

    assign m_valid = (state_q == BUSY);
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign m_wstrb = m_wstrb_q;

    assign i_ready = m_ready && (state_q == BUSY) && (grant_q == GNT_I);
    assign d_ready = m_ready && (state_q == BUSY) && (grant_q == GNT_D);
    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: round-robin and fixed-priority arbiters each behind a single-wait-state memory.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        i_valid, d_valid;
    logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
    logic [3:0]  i_wstrb, d_wstrb;

    logic        r_i_ready, r_d_ready, r_m_valid, r_m_ready;
    logic [31:0] r_i_rdata, r_d_rdata, r_m_addr, r_m_wdata, r_m_rdata;
    logic [3:0]  r_m_wstrb;

    logic        f_i_ready, f_d_ready, f_m_valid, f_m_ready;
    logic [31:0] f_i_rdata, f_d_rdata, f_m_addr, f_m_wdata;
    logic [3:0]  f_m_wstrb;

    logic [7:0]  mem0 [0:255];
    logic [31:0] acc0;
    logic [31:0] f_m_rdata;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.FIXED_PRIO(0)) u_rr (
        .clk(clk), .resetn(resetn),
        .i_valid(i_valid), .i_ready(r_i_ready), .i_addr(i_addr), .i_rdata(r_i_rdata),
        .i_wdata(i_wdata), .i_wstrb(i_wstrb),
        .d_valid(d_valid), .d_ready(r_d_ready), .d_addr(d_addr), .d_rdata(r_d_rdata),
        .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .m_valid(r_m_valid), .m_ready(r_m_ready), .m_addr(r_m_addr), .m_rdata(r_m_rdata),
        .m_wdata(r_m_wdata), .m_wstrb(r_m_wstrb)
    );

    mem_arbiter #(.FIXED_PRIO(1)) u_fp (
        .clk(clk), .resetn(resetn),
        .i_valid(i_valid), .i_ready(f_i_ready), .i_addr(i_addr), .i_rdata(f_i_rdata),
        .i_wdata(i_wdata), .i_wstrb(i_wstrb),
        .d_valid(d_valid), .d_ready(f_d_ready), .d_addr(d_addr), .d_rdata(f_d_rdata),
        .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .m_valid(f_m_valid), .m_ready(f_m_ready), .m_addr(f_m_addr), .m_rdata(f_m_rdata),
        .m_wdata(f_m_wdata), .m_wstrb(f_m_wstrb)
    );

    // Single-wait-state memory: accepts a fresh valid, answers one cycle later.
    always @(posedge clk) begin
        if (!resetn) begin
            for (int k = 0; k < 256; k++) mem0[k] <= 8'h00;
            mem0[8'h10] <= 8'h13;
            mem0[8'h20] <= 8'h78;
            mem0[8'h21] <= 8'h56;
            mem0[8'h22] <= 8'hFE;
            mem0[8'h23] <= 8'hCA;
            r_m_ready <= 1'b0;
            r_m_rdata <= 32'h0;
            acc0      <= 32'h0;
        end else if (r_m_valid && !r_m_ready) begin
            r_m_ready <= 1'b1;
            acc0      <= acc0 + 32'd1;
            r_m_rdata <= {mem0[{r_m_addr[7:2], 2'd3}], mem0[{r_m_addr[7:2], 2'd2}],
                          mem0[{r_m_addr[7:2], 2'd1}], mem0[{r_m_addr[7:2], 2'd0}]};
            if (r_m_wstrb[0]) mem0[{r_m_addr[7:2], 2'd0}] <= r_m_wdata[7:0];
            if (r_m_wstrb[1]) mem0[{r_m_addr[7:2], 2'd1}] <= r_m_wdata[15:8];
            if (r_m_wstrb[2]) mem0[{r_m_addr[7:2], 2'd2}] <= r_m_wdata[23:16];
            if (r_m_wstrb[3]) mem0[{r_m_addr[7:2], 2'd3}] <= r_m_wdata[31:24];
        end else begin
            r_m_ready <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (!resetn) begin
            f_m_ready <= 1'b0;
        end else begin
            f_m_ready <= f_m_valid && !f_m_ready;
        end
    end
    assign f_m_rdata = 32'h0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        i_valid = 1'b0; i_addr = 32'h0; i_wdata = 32'h0; i_wstrb = 4'h0;
        d_valid = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_wstrb = 4'h0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        idle_inputs();
        tick();
        tick();
        resetn = 1'b1;
    endtask

    logic [31:0] tie_addr [0:3];

    initial begin
        tie_addr[0] = 32'h10; tie_addr[1] = 32'h30; tie_addr[2] = 32'h10; tie_addr[3] = 32'h30;

        // Reset state
        resetn = 1'b0;
        idle_inputs();
        tick();
        tick();
        check("rst_m_valid", {31'h0, r_m_valid}, 32'h0);
        check("rst_m_addr", r_m_addr, 32'h0);
        check("rst_m_wdata", r_m_wdata, 32'h0);
        check("rst_m_wstrb", {28'h0, r_m_wstrb}, 32'h0);
        check("rst_i_ready", {31'h0, r_i_ready}, 32'h0);
        check("rst_d_ready", {31'h0, r_d_ready}, 32'h0);
        resetn = 1'b1;
        tick();
        check("post_rst_i_ready", {31'h0, r_i_ready}, 32'h0);

        // Single fetch
        do_reset();
        i_valid = 1'b1; i_addr = 32'h10;
        check("fetch_c0_m_valid", {31'h0, r_m_valid}, 32'h0);
        tick();
        check("fetch_c1_m_valid", {31'h0, r_m_valid}, 32'h1);
        check("fetch_c1_m_addr", r_m_addr, 32'h10);
        check("fetch_c1_i_ready", {31'h0, r_i_ready}, 32'h0);
        tick();
        check("fetch_c2_i_ready", {31'h0, r_i_ready}, 32'h1);
        check("fetch_c2_i_rdata", r_i_rdata, 32'h00000013);
        check("fetch_c2_d_ready", {31'h0, r_d_ready}, 32'h0);
        tick();
        i_valid = 1'b0;
        check("fetch_c3_m_valid", {31'h0, r_m_valid}, 32'h0);
        check("fetch_c3_i_ready", {31'h0, r_i_ready}, 32'h0);
        tick();
        check("fetch_c4_m_valid", {31'h0, r_m_valid}, 32'h0);

        // Persistent tie, round-robin: I, D, I, D
        do_reset();
        i_valid = 1'b1; i_addr = 32'h10;
        d_valid = 1'b1; d_addr = 32'h30;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rr_m_valid", {31'h0, r_m_valid}, 32'h1);
            check("rr_m_addr", r_m_addr, tie_addr[k]);
            tick();
            check("rr_i_ready", {31'h0, r_i_ready}, (k % 2 == 0) ? 32'h1 : 32'h0);
            check("rr_d_ready", {31'h0, r_d_ready}, (k % 2 == 1) ? 32'h1 : 32'h0);
            tick();
            check("rr_post_ready_m_valid", {31'h0, r_m_valid}, 32'h0);
        end
        idle_inputs();
        tick();
        check("rr_accept_count", acc0, 32'd4);

        // Fixed priority: data first, then instruction
        do_reset();
        i_valid = 1'b1; i_addr = 32'h10;
        d_valid = 1'b1; d_addr = 32'h30;
        tick();
        check("fp_c1_m_addr", f_m_addr, 32'h30);
        tick();
        check("fp_c2_d_ready", {31'h0, f_d_ready}, 32'h1);
        check("fp_c2_i_ready", {31'h0, f_i_ready}, 32'h0);
        tick();
        d_valid = 1'b0;
        check("fp_c3_m_valid", {31'h0, f_m_valid}, 32'h0);
        tick();
        check("fp_c4_m_valid", {31'h0, f_m_valid}, 32'h1);
        check("fp_c4_m_addr", f_m_addr, 32'h10);
        tick();
        check("fp_c5_i_ready", {31'h0, f_i_ready}, 32'h1);
        tick();
        idle_inputs();

        // Halfword write then read back
        do_reset();
        d_valid = 1'b1; d_addr = 32'h20; d_wdata = 32'hABCD1234; d_wstrb = 4'b0011;
        tick();
        check("wr_m_wstrb", {28'h0, r_m_wstrb}, 32'h3);
        check("wr_m_wdata", r_m_wdata, 32'hABCD1234);
        tick();
        check("wr_d_ready", {31'h0, r_d_ready}, 32'h1);
        tick();
        d_wdata = 32'h0; d_wstrb = 4'b0000;
        check("wr_byte20", {24'h0, mem0[8'h20]}, 32'h34);
        check("wr_byte21", {24'h0, mem0[8'h21]}, 32'h12);
        check("wr_byte22", {24'h0, mem0[8'h22]}, 32'hFE);
        tick();
        check("rd_m_wstrb", {28'h0, r_m_wstrb}, 32'h0);
        tick();
        check("rd_d_ready", {31'h0, r_d_ready}, 32'h1);
        check("rd_d_rdata", r_d_rdata, 32'hCAFE1234);
        tick();
        idle_inputs();

        // Field change after grant does not reach the memory
        do_reset();
        d_valid = 1'b1; d_addr = 32'h40;
        tick();
        d_addr = 32'h80;
        check("hold_c1_m_addr", r_m_addr, 32'h40);
        tick();
        check("hold_c2_m_addr", r_m_addr, 32'h40);
        check("hold_c2_d_ready", {31'h0, r_d_ready}, 32'h1);
        tick();
        idle_inputs();

        // Reset while BUSY, then first tie goes to instruction
        do_reset();
        i_valid = 1'b1; i_addr = 32'h10; d_addr = 32'h30;
        tick();
        check("rb_c1_m_valid", {31'h0, r_m_valid}, 32'h1);
        resetn = 1'b0;
        tick();
        check("rb_c2_m_valid", {31'h0, r_m_valid}, 32'h0);
        check("rb_c2_i_ready", {31'h0, r_i_ready}, 32'h0);
        check("rb_c2_d_ready", {31'h0, r_d_ready}, 32'h0);
        resetn = 1'b1;
        d_valid = 1'b1;
        tick();
        check("rb_c3_m_valid", {31'h0, r_m_valid}, 32'h1);
        check("rb_c3_m_addr", r_m_addr, 32'h10);
        tick();
        check("rb_c4_i_ready", {31'h0, r_i_ready}, 32'h1);
        check("rb_c4_d_ready", {31'h0, r_d_ready}, 32'h0);
        tick();
        idle_inputs();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master, one-slave arbiter for the vigna valid/ready memory bus. It shares a single memory port (the simulation memory model or a real RAM) between the core's instruction-fetch port and its data load/store port. A two-way round-robin (or fixed-priority) grant is followed by one outstanding transaction at a time. Request fields are latched at grant, so the memory sees stable inputs for the whole access.

## Interface
- `FIXED_PRIO`, default 0: 0 selects round-robin; 1 gives the data port strict priority.
- `clk` in 1: single clock; all logic on the rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `i_valid` in 1: instruction request.
- `i_ready` out 1: one-cycle completion pulse to the instruction port.
- `i_addr` in 32: instruction address.
- `i_rdata` out 32: read data to the instruction port.
- `i_wdata` in 32: instruction-port write data (normally unused).
- `i_wstrb` in 4: instruction-port write strobes (normally 0).
- `d_valid`, `d_ready`, `d_addr`, `d_rdata`, `d_wdata`, `d_wstrb`: same as the `i_*` group, for the data port.
- `m_valid` out 1: memory request.
- `m_ready` in 1: one-cycle completion pulse from memory.
- `m_addr` out 32: latched address.
- `m_rdata` in 32: memory read data.
- `m_wdata` out 32: latched write data.
- `m_wstrb` out 4: latched strobes; 0 means read. Memory honours 4'b1111, 4'b0011 and 4'b0001.

## Operation
- States: IDLE, BUSY.
- **IDLE**
  - If no request is pending, stay in IDLE.
  - Otherwise pick a winner and latch its addr, wdata and wstrb into the `m_*` registers.
  - Store the winner in `grant` (0 = instruction, 1 = data) and go to BUSY.
- **Winner selection**
  - Only one port valid: that port wins.
  - Both valid, `FIXED_PRIO`=1: data wins.
  - Both valid, `FIXED_PRIO`=0: the port not in `last` wins.
  - `last` updates to the winner at each grant.
- **BUSY**
  - `m_valid`=1.
  - When `m_ready`=1, return to IDLE. `m_valid` is low in the following cycle.
- **Ready routing**
  - `i_ready` = `m_ready` & BUSY & `grant`==0.
  - `d_ready` = `m_ready` & BUSY & `grant`==1.
  - `m_ready` while in IDLE is ignored.
- **Read data**
  - `i_rdata` and `d_rdata` both carry `m_rdata` combinationally.
  - Each is meaningful only while that port's ready is high.
- **Requester rules**
  - A requester holds valid and its fields stable until its ready pulse.
  - It drops valid, or presents a new request, on the edge after the pulse.
  - Because of latching, a field change after grant does not affect the access in flight.
- The loser's valid stays pending and is served at the next IDLE evaluation, so neither port starves in round-robin mode.

## Timing
- Reset: state=IDLE, `grant`=0, `last`=1 (instruction wins the first tie), `m_valid`=0, `m_addr`=0, `m_wdata`=0, `m_wstrb`=0.
- `i_ready` and `d_ready` are 0 during and after reset until a transaction completes.
- Against the single-wait-state memory:
  - cycle 0: request seen in IDLE;
  - cycle 1: `m_valid` high;
  - cycle 2: `m_ready` and the requester's ready high;
  - cycle 3: IDLE, next arbitration.
- Request to ready is 2 cycles; back-to-back throughput is one access per 3 cycles.
- `m_valid` must be low in the cycle after `m_ready`. The memory re-samples valid in that cycle, and a held valid would start a duplicate write.
- A request arriving while BUSY waits; no pre-grant is allowed.
- Reset mid-BUSY drops `m_valid` next cycle and emits no ready pulse. The memory shares `resetn`, so no half transaction survives.
- A new valid on one port coinciding with the other port's ready pulse is arbitrated in the following IDLE cycle, not the ready cycle.

## Structure
- Shared package `vigna_bus_pkg`:
  - state encodings IDLE=1'b0, BUSY=1'b1;
  - grant encodings GNT_I=1'b0, GNT_D=1'b1;
  - strobe constants WSTRB_RD=4'b0000, WSTRB_B=4'b0001, WSTRB_H=4'b0011, WSTRB_W=4'b1111.
- One natural sub-module, `arb_rr2`: combinational 2-way pick from (`req_i`, `req_d`, `last`, `FIXED_PRIO`) to the winner. It is reused by later multi-port variants.
- Latches, FSM and ready routing stay in `mem_arbiter`.

## Test plan
- Single fetch: `i_valid` with `i_addr`=0x10, `i_wstrb`=0, memory word 0x00000013 -> `m_valid` in cycle 1; `i_ready` for one cycle in cycle 2 with `i_rdata`=0x00000013; `d_ready` stays 0.
- Tie, round-robin: both valid from reset, persistent -> grants I, D, I, D; each ready spaced 3 cycles apart; no duplicate `m_valid` in any post-ready cycle.
- Fixed priority (`FIXED_PRIO`=1): both valid -> data served first; instruction served in the next slot.
- Write then read:
  - `d_wstrb`=4'b0011, `d_addr`=0x20, `d_wdata`=0xABCD1234 -> bytes 0x20/0x21 = 0x34/0x12;
  - byte 0x22 unchanged;
  - a following read of 0x20 returns {old[31:16], 0x1234}.
- Field change after grant: `d_addr` switched from 0x40 to 0x80 in cycle 1 -> `m_addr` stays 0x40 for the whole access.
- Reset in BUSY: `resetn`=0 in cycle 1 -> `m_valid`=0 next cycle; no ready pulse; state IDLE; the first tie after release goes to the instruction port.
